// File: rtl/ram_pkg.sv
// Shared constants and helpers for the simple dual-port RAM.
package ram_pkg;

  localparam string WRITE_FIRST = "write_first";
  localparam string READ_FIRST  = "read_first";

  localparam string PRIM_AUTO        = "auto";
  localparam string PRIM_BLOCK       = "block";
  localparam string PRIM_DISTRIBUTED = "distributed";
  localparam string PRIM_REGISTER    = "register";

  localparam string COMMON_CLOCK = "common_clock";

  function automatic int unsigned num_lanes(input int unsigned data_width,
                                            input int unsigned byte_width);
    return data_width / byte_width;
  endfunction

endpackage

// File: rtl/simple_dual_port_ram_collision_merge.sv
// Same-address collision resolution: picks the read-next word per write mode.
module sdpram_collision_merge
  import ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned BYTE_WRITE_WIDTH = 32,
  parameter string       WRITE_MODE       = "write_first",
  localparam int unsigned NUM_LANES       = num_lanes(DATA_WIDTH, BYTE_WRITE_WIDTH)
) (
  input  logic [DATA_WIDTH-1:0] old_word,
  input  logic [DATA_WIDTH-1:0] new_word,
  input  logic [NUM_LANES-1:0]  lane_we,
  input  logic                  match,
  output logic [DATA_WIDTH-1:0] rd_next_c
);

  localparam bit IS_WRITE_FIRST = (WRITE_MODE == WRITE_FIRST);

  logic [DATA_WIDTH-1:0] merged;

  // Written lanes take the new data, untouched lanes keep the stored value.
  always_comb begin
    merged = old_word;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (lane_we[i]) merged[i*BYTE_WRITE_WIDTH +: BYTE_WRITE_WIDTH] =
          new_word[i*BYTE_WRITE_WIDTH +: BYTE_WRITE_WIDTH];
    end
    rd_next_c = (IS_WRITE_FIRST && match) ? merged : old_word;
  end

endmodule

// File: rtl/simple_dual_port_ram.sv
// Single-clock simple dual-port RAM: byte-lane write port A, registered read port B.
module simple_dual_port_ram
  import ram_pkg::*;
#(
  parameter int unsigned DATA_DEPTH       = 128,
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned BYTE_WRITE_WIDTH = 32,
  parameter string       CLOCKING_MODE    = "common_clock",
  parameter string       WRITE_MODE       = "write_first",
  parameter string       MEMORY_PRIMITIVE = "auto",
  localparam int unsigned ADDR_WIDTH      = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1,
  localparam int unsigned NUM_LANES       = num_lanes(DATA_WIDTH, BYTE_WRITE_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rstb_n,
  input  logic                  en_a_i,
  input  logic [NUM_LANES-1:0]  we_a_i,
  input  logic [ADDR_WIDTH-1:0] addr_a_i,
  input  logic [DATA_WIDTH-1:0] data_a_i,
  input  logic                  en_b_i,
  input  logic [ADDR_WIDTH-1:0] addr_b_i,
  output logic [DATA_WIDTH-1:0] data_b_o
);

  if (CLOCKING_MODE != COMMON_CLOCK) begin : g_bad_clocking
    $error("simple_dual_port_ram: CLOCKING_MODE must be common_clock");
  end
  if (WRITE_MODE != WRITE_FIRST && WRITE_MODE != READ_FIRST) begin : g_bad_write_mode
    $error("simple_dual_port_ram: WRITE_MODE must be write_first or read_first");
  end
  if (MEMORY_PRIMITIVE != PRIM_AUTO && MEMORY_PRIMITIVE != PRIM_BLOCK &&
      MEMORY_PRIMITIVE != PRIM_DISTRIBUTED && MEMORY_PRIMITIVE != PRIM_REGISTER)
  begin : g_bad_primitive
    $error("simple_dual_port_ram: unknown MEMORY_PRIMITIVE");
  end
  if (BYTE_WRITE_WIDTH == 0 || (DATA_WIDTH % BYTE_WRITE_WIDTH) != 0) begin : g_bad_lanes
    $error("simple_dual_port_ram: DATA_WIDTH must be a multiple of BYTE_WRITE_WIDTH");
  end

  // Zero-initialised so unwritten locations never read back as X.
  logic [DATA_WIDTH-1:0] mem [DATA_DEPTH] = '{default: '0};

  logic                  a_in_range_c;
  logic                  b_in_range_c;
  logic                  write_c;
  logic                  match_c;
  logic [DATA_WIDTH-1:0] old_word_c;
  logic [DATA_WIDTH-1:0] rd_next_c;

  assign a_in_range_c = 32'(addr_a_i) < DATA_DEPTH;
  assign b_in_range_c = 32'(addr_b_i) < DATA_DEPTH;
  assign write_c      = rstb_n && en_a_i && a_in_range_c;
  assign match_c      = write_c && (|we_a_i) && (addr_a_i == addr_b_i);
  assign old_word_c   = b_in_range_c ? mem[addr_b_i] : '0;

  // Port A: lane-masked write; out-of-range and in-reset writes are dropped.
  always_ff @(posedge clk) begin
    if (write_c) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (we_a_i[i]) mem[addr_a_i][i*BYTE_WRITE_WIDTH +: BYTE_WRITE_WIDTH] <=
            data_a_i[i*BYTE_WRITE_WIDTH +: BYTE_WRITE_WIDTH];
      end
    end
  end

  sdpram_collision_merge #(
    .DATA_WIDTH      (DATA_WIDTH),
    .BYTE_WRITE_WIDTH(BYTE_WRITE_WIDTH),
    .WRITE_MODE      (WRITE_MODE)
  ) u_merge (
    .old_word (old_word_c),
    .new_word (data_a_i),
    .lane_we  (we_a_i),
    .match    (match_c),
    .rd_next_c(rd_next_c)
  );

  // Port B: registered read, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rstb_n) begin
    if (!rstb_n) begin
      data_b_o <= '0;
    end else if (en_b_i) begin
      data_b_o <= rd_next_c;
    end
  end

endmodule

// File: tb/tb_simple_dual_port_ram.sv
// Directed self-checking bench: write-first, read-first and depth-5 RAM instances.
module tb_simple_dual_port_ram;

  logic        clk;
  logic        rstb_n;
  logic        en_a;
  logic [3:0]  we_a;
  logic [6:0]  addr_a;
  logic [31:0] data_a;
  logic        en_b;
  logic [6:0]  addr_b;
  logic [31:0] q_wf;
  logic [31:0] q_rf;
  logic [31:0] q_d5;

  int errors = 0;
  int checks = 0;

  simple_dual_port_ram #(
    .DATA_DEPTH(128), .DATA_WIDTH(32), .BYTE_WRITE_WIDTH(8),
    .CLOCKING_MODE("common_clock"), .WRITE_MODE("write_first"), .MEMORY_PRIMITIVE("auto")
  ) u_wf (
    .clk(clk), .rstb_n(rstb_n), .en_a_i(en_a), .we_a_i(we_a), .addr_a_i(addr_a),
    .data_a_i(data_a), .en_b_i(en_b), .addr_b_i(addr_b), .data_b_o(q_wf)
  );

  simple_dual_port_ram #(
    .DATA_DEPTH(128), .DATA_WIDTH(32), .BYTE_WRITE_WIDTH(8),
    .CLOCKING_MODE("common_clock"), .WRITE_MODE("read_first"), .MEMORY_PRIMITIVE("block")
  ) u_rf (
    .clk(clk), .rstb_n(rstb_n), .en_a_i(en_a), .we_a_i(we_a), .addr_a_i(addr_a),
    .data_a_i(data_a), .en_b_i(en_b), .addr_b_i(addr_b), .data_b_o(q_rf)
  );

  simple_dual_port_ram #(
    .DATA_DEPTH(5), .DATA_WIDTH(32), .BYTE_WRITE_WIDTH(8),
    .CLOCKING_MODE("common_clock"), .WRITE_MODE("write_first"), .MEMORY_PRIMITIVE("register")
  ) u_d5 (
    .clk(clk), .rstb_n(rstb_n), .en_a_i(en_a), .we_a_i(we_a), .addr_a_i(addr_a[2:0]),
    .data_a_i(data_a), .en_b_i(en_b), .addr_b_i(addr_b[2:0]), .data_b_o(q_d5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [6:0] a, input logic [31:0] d, input logic [3:0] w);
    en_a = 1'b1; we_a = w; addr_a = a; data_a = d;
    step();
    en_a = 1'b0; we_a = '0;
  endtask

  task automatic rd(input logic [6:0] a);
    en_b = 1'b1; addr_b = a;
    step();
    en_b = 1'b0;
  endtask

  task automatic test_reset();
    rstb_n = 1'b0; en_a = 1'b0; we_a = '0; addr_a = '0; data_a = '0; en_b = 1'b0; addr_b = '0;
    #1;
    checks++; if (q_wf !== 32'h0) begin errors++; $display("FAIL reset_wf: got %h want %h", q_wf, 32'h0); end
    checks++; if (q_rf !== 32'h0) begin errors++; $display("FAIL reset_rf: got %h want %h", q_rf, 32'h0); end
    checks++; if (q_d5 !== 32'h0) begin errors++; $display("FAIL reset_d5: got %h want %h", q_d5, 32'h0); end
    step(); step();
    rstb_n = 1'b1;
    step();
  endtask

  task automatic test_write_read();
    wr(7'd3, 32'hDEADBEEF, 4'hF);
    checks++; if (q_wf !== 32'h0) begin errors++; $display("FAIL pre_read: got %h want %h", q_wf, 32'h0); end
    rd(7'd3);
    checks++; if (q_wf !== 32'hDEADBEEF) begin errors++; $display("FAIL read3: got %h want %h", q_wf, 32'hDEADBEEF); end
  endtask

  task automatic test_collision();
    wr(7'd5, 32'h11111111, 4'hF);
    en_a = 1'b1; we_a = 4'hF; addr_a = 7'd5; data_a = 32'h22222222;
    en_b = 1'b1; addr_b = 7'd5;
    step();
    en_a = 1'b0; we_a = '0; en_b = 1'b0;
    checks++; if (q_wf !== 32'h22222222) begin errors++; $display("FAIL coll_wf: got %h want %h", q_wf, 32'h22222222); end
    checks++; if (q_rf !== 32'h11111111) begin errors++; $display("FAIL coll_rf: got %h want %h", q_rf, 32'h11111111); end
    checks++; if (q_d5 !== 32'h0) begin errors++; $display("FAIL coll_oob_d5: got %h want %h", q_d5, 32'h0); end
    rd(7'd5);
    checks++; if (q_rf !== 32'h22222222) begin errors++; $display("FAIL coll_rf_next: got %h want %h", q_rf, 32'h22222222); end
  endtask

  task automatic test_byte_lanes();
    wr(7'd0, 32'hAABBCCDD, 4'hF);
    en_a = 1'b1; we_a = 4'b0101; addr_a = 7'd0; data_a = 32'h11223344;
    en_b = 1'b1; addr_b = 7'd0;
    step();
    en_a = 1'b0; we_a = '0; en_b = 1'b0;
    checks++; if (q_wf !== 32'hAA22CC44) begin errors++; $display("FAIL lane_coll_wf: got %h want %h", q_wf, 32'hAA22CC44); end
    checks++; if (q_rf !== 32'hAABBCCDD) begin errors++; $display("FAIL lane_coll_rf: got %h want %h", q_rf, 32'hAABBCCDD); end
    rd(7'd0);
    checks++; if (q_wf !== 32'hAA22CC44) begin errors++; $display("FAIL lane_wf: got %h want %h", q_wf, 32'hAA22CC44); end
    checks++; if (q_rf !== 32'hAA22CC44) begin errors++; $display("FAIL lane_rf: got %h want %h", q_rf, 32'hAA22CC44); end
  endtask

  task automatic test_enables();
    en_b = 1'b0; addr_b = 7'd3;
    step();
    addr_b = 7'd5;
    step();
    checks++; if (q_wf !== 32'hAA22CC44) begin errors++; $display("FAIL hold_b: got %h want %h", q_wf, 32'hAA22CC44); end
    en_a = 1'b0; we_a = 4'hF; addr_a = 7'd3; data_a = 32'h0;
    step();
    we_a = '0;
    rd(7'd3);
    checks++; if (q_wf !== 32'hDEADBEEF) begin errors++; $display("FAIL en_a_off: got %h want %h", q_wf, 32'hDEADBEEF); end
  endtask

  task automatic test_fifo_wrap();
    logic [6:0]  tail;
    logic [31:0] exp_q [5];
    exp_q = '{32'd9, 32'd1, 32'd2, 32'd3, 32'd4};
    tail = '0;
    for (int i = 0; i < 5; i++) begin
      wr(tail, 32'(i), 4'hF);
      tail = (tail == 7'd4) ? 7'd0 : tail + 7'd1;
    end
    wr(tail, 32'd9, 4'hF);
    for (int i = 0; i < 5; i++) begin
      rd(7'(i));
      checks++;
      if (q_d5 !== exp_q[i]) begin
        errors++; $display("FAIL fifo_rd%0d: got %h want %h", i, q_d5, exp_q[i]);
      end
    end
    wr(7'd6, 32'h77, 4'hF);
    rd(7'd6);
    checks++; if (q_d5 !== 32'h0) begin errors++; $display("FAIL oob_rd_d5: got %h want %h", q_d5, 32'h0); end
    checks++; if (q_wf !== 32'h77) begin errors++; $display("FAIL rd6_wf: got %h want %h", q_wf, 32'h77); end
  endtask

  task automatic test_async_reset();
    wr(7'd0, 32'h5, 4'hF);
    rd(7'd0);
    checks++; if (q_wf !== 32'h5) begin errors++; $display("FAIL pre_rst: got %h want %h", q_wf, 32'h5); end
    #2;
    rstb_n = 1'b0;
    #1;
    checks++; if (q_wf !== 32'h0) begin errors++; $display("FAIL async_rst: got %h want %h", q_wf, 32'h0); end
    en_a = 1'b1; we_a = 4'hF; addr_a = 7'd0; data_a = 32'h12345678;
    en_b = 1'b1; addr_b = 7'd0;
    step();
    en_a = 1'b0; we_a = '0; en_b = 1'b0;
    checks++; if (q_wf !== 32'h0) begin errors++; $display("FAIL rst_hold: got %h want %h", q_wf, 32'h0); end
    rstb_n = 1'b1;
    step();
    rd(7'd0);
    checks++; if (q_wf !== 32'h5) begin errors++; $display("FAIL post_rst: got %h want %h", q_wf, 32'h5); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_collision();
    test_byte_lanes();
    test_enables();
    test_fifo_wrap();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
